// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: slave-side SPI word engine, all CPOL/CPHA modes.
// Optional LSB-first support when SPI_SLAVE_LSBFE_EN is defined (adds lsbfe).
//
// Ports:
//   pclk, preset_n         system clock, async active-low reset
//   slave_en, cpol, cpha   enable and clock mode
//   ss_n, sclk, mosi       async pad inputs (synchronised here)
//   miso, miso_oe          serial out and its pad enable
//   tx_data/tx_load        one-deep TX buffer write; tx_empty = buffer free
//   rx_data/rx_valid       last received word; rx_ack clears rx_valid
//   rx_ovr/ovr_clr         sticky overrun flag and its clear
//   tip                    transfer in progress
//   lsbfe                  (macro only) 1 = LSB first, latched in LOAD
module spi_slave_shifter #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              slave_en,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic              mosi,
`ifdef SPI_SLAVE_LSBFE_EN
  input  logic              lsbfe,
`endif
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_empty,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_ovr,
  input  logic              ovr_clr,
  output logic              tip
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [SYNC_STAGES-1:0] r_ss_sy;
  logic [SYNC_STAGES-1:0] r_sclk_sy;
  logic [SYNC_STAGES-1:0] r_mosi_sy;
  logic                   r_sclk_d;

  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_tx_buf;
  logic              r_tx_empty;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_ovr;

  logic              w_ss;
  logic              w_sclk;
  logic              w_mosi;
  logic              w_lead;
  logic              w_trail;
  logic              w_sample;
  logic              w_shift;
  logic              w_abort;
  logic              w_load;
  logic              w_smp;
  logic              w_done;
  logic              w_adv;
  logic              w_take;
  logic              w_vld_eff;
  logic              w_lsb;
  logic [DATA_W-1:0] w_rx_nxt;
  logic [DATA_W-1:0] w_tx_src;

  // Input synchronisers, reset to all-ones (SS inactive).
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_ss_sy   <= '1;
      r_sclk_sy <= '1;
      r_mosi_sy <= '1;
      r_sclk_d  <= 1'b1;
    end else begin
      r_ss_sy   <= {r_ss_sy[SYNC_STAGES-2:0], ss_n};
      r_sclk_sy <= {r_sclk_sy[SYNC_STAGES-2:0], sclk};
      r_mosi_sy <= {r_mosi_sy[SYNC_STAGES-2:0], mosi};
      r_sclk_d  <= w_sclk;
    end
  end

  assign w_ss     = r_ss_sy[SYNC_STAGES-1];
  assign w_sclk   = r_sclk_sy[SYNC_STAGES-1];
  assign w_mosi   = r_mosi_sy[SYNC_STAGES-1];
  assign w_lead   = (r_sclk_d == cpol) && (w_sclk != cpol);
  assign w_trail  = (r_sclk_d != cpol) && (w_sclk == cpol);
  assign w_sample = cpha ? w_trail : w_lead;
  assign w_shift  = cpha ? w_lead : w_trail;
  assign w_abort  = w_ss || !slave_en;

`ifdef SPI_SLAVE_LSBFE_EN
  logic r_lsb;
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)   r_lsb <= 1'b0;
    else if (w_load) r_lsb <= lsbfe;
  end
  assign w_lsb = r_lsb;
`else
  assign w_lsb = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= S_IDLE;
    else           r_state <= w_nxt;
  end

  // No advance at count 0: the loaded MSB is already on miso. In
  // cpha=1 the first leading edge therefore just presents that bit.
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_smp  = 1'b0;
    w_done = 1'b0;
    w_adv  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_abort) w_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_abort) begin
          w_nxt = S_IDLE;
        end else begin
          w_nxt  = S_SHIFT;
          w_load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_abort) begin
          w_nxt = S_IDLE;
        end else begin
          w_smp  = w_sample;
          w_done = w_sample && (r_cnt == LAST);
          w_adv  = w_shift && (r_cnt != '0);
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_take    = w_load || w_done;
  assign w_tx_src  = r_tx_empty ? '1 : r_tx_buf;
  assign w_vld_eff = r_rx_valid && !rx_ack;
  assign w_rx_nxt  = w_lsb ? {w_mosi, r_rx_sh[DATA_W-1:1]}
                           : {r_rx_sh[DATA_W-2:0], w_mosi};

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_cnt      <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= '0;
      r_tx_buf   <= '0;
      r_tx_empty <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      if (w_load || w_done || w_abort) r_cnt <= '0;
      else if (w_smp)                  r_cnt <= r_cnt + CW'(1);

      if (w_smp) r_rx_sh <= w_rx_nxt;

      if (w_take)     r_tx_sh <= w_tx_src;
      else if (w_adv) r_tx_sh <= w_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);

      // A consume and a write in one cycle: shifter gets the old
      // content, buffer takes the new word.
      if (w_take) begin
        if (tx_load) begin
          r_tx_buf   <= tx_data;
          r_tx_empty <= 1'b0;
        end else begin
          r_tx_empty <= 1'b1;
        end
      end else if (tx_load && r_tx_empty) begin
        r_tx_buf   <= tx_data;
        r_tx_empty <= 1'b0;
      end

      // An ack in the completion cycle frees the slot first.
      if (w_done && !w_vld_eff) begin
        r_rx_data  <= w_rx_nxt;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end

      if (w_done && w_vld_eff) r_rx_ovr <= 1'b1;
      else if (ovr_clr)        r_rx_ovr <= 1'b0;
    end
  end

  assign miso     = w_lsb ? r_tx_sh[0] : r_tx_sh[DATA_W-1];
  assign miso_oe  = (r_state != S_IDLE);
  assign tip      = (r_state != S_IDLE);
  assign tx_empty = r_tx_empty;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_ovr   = r_rx_ovr;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter: directed bench for spi_slave_shifter.
// Acts as SPI master on the pads, sclk = pclk/8.
module tb_spi_slave_shifter;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       slave_en;
  logic       cpol;
  logic       cpha;
  logic       ss_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_ovr;
  logic       ovr_clr;
  logic       tip;

  int n_chk = 0;
  int n_fail = 0;
  int rises = 0;
  logic rv_q = 1'b0;

  always #5 pclk = ~pclk;

  spi_slave_shifter #(
    .DATA_W(8),
    .SYNC_STAGES(2)
  ) dut (
    .pclk(pclk),
    .preset_n(preset_n),
    .slave_en(slave_en),
    .cpol(cpol),
    .cpha(cpha),
    .ss_n(ss_n),
    .sclk(sclk),
    .mosi(mosi),
`ifdef SPI_SLAVE_LSBFE_EN
    .lsbfe(1'b0),
`endif
    .miso(miso),
    .miso_oe(miso_oe),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .tx_empty(tx_empty),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .rx_ovr(rx_ovr),
    .ovr_clr(ovr_clr),
    .tip(tip)
  );

  always @(posedge pclk) begin
    if (rx_valid && !rv_q) rises++;
    rv_q <= rx_valid;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    cyc(1);
    rx_ack = 1'b0;
  endtask

  task automatic ss_lo();
    ss_n = 1'b0;
    cyc(8);
  endtask

  task automatic ss_hi();
    cyc(4);
    ss_n = 1'b1;
    cyc(8);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nb,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        mosi = mo[7-i];
        cyc(4);
        mi[7-i] = miso;
        sclk = ~cpol;
        cyc(4);
        sclk = cpol;
      end else begin
        cyc(4);
        sclk = ~cpol;
        mosi = mo[7-i];
        cyc(4);
        mi[7-i] = miso;
        sclk = cpol;
      end
    end
  endtask

  task automatic set_mode(input logic [1:0] md);
    cpol = md[1];
    cpha = md[0];
    sclk = md[1];
    cyc(6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi;
    logic [7:0] mi2;
    int r0;
    int t;
    preset_n = 1'b0;
    slave_en = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    ss_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    tx_data = '0;
    tx_load = 1'b0;
    rx_ack = 1'b0;
    ovr_clr = 1'b0;
    cyc(3);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_ovr", rx_ovr, 0);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_tip", tip, 0);
    preset_n = 1'b1;
    cyc(6);

    // mode 0
    load(8'hA5);
    chk("m0_tx_full", tx_empty, 0);
    r0 = rises;
    ss_lo();
    chk("m0_tip", tip, 1);
    chk("m0_oe", miso_oe, 1);
    xfer(8'h3C, 8, mi);
    ss_hi();
    chk("m0_miso", mi, 8'hA5);
    chk("m0_rx", rx_data, 8'h3C);
    chk("m0_valid", rx_valid, 1);
    chk("m0_rises", rises - r0, 1);
    chk("m0_empty", tx_empty, 1);
    chk("m0_tip_end", tip, 0);
    ack();
    chk("m0_ack", rx_valid, 0);

    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1:0]);
      load(8'hA5);
      ss_lo();
      xfer(8'hC3, 8, mi);
      ss_hi();
      chk($sformatf("m%0d_miso", m), mi, 8'hA5);
      chk($sformatf("m%0d_rx", m), rx_data, 8'hC3);
      ack();
    end

    // back-to-back, buffer loaded once
    set_mode(2'b00);
    load(8'hA5);
    r0 = rises;
    ss_lo();
    xfer(8'h5A, 8, mi);
    chk("b2b_rx1", rx_data, 8'h5A);
    chk("b2b_v1", rx_valid, 1);
    ack();
    xfer(8'h96, 8, mi2);
    ss_hi();
    chk("b2b_miso1", mi, 8'hA5);
    chk("b2b_miso2", mi2, 8'hFF);
    chk("b2b_rx2", rx_data, 8'h96);
    chk("b2b_rises", rises - r0, 2);
    chk("b2b_ovr", rx_ovr, 0);
    ack();

    // overrun
    ss_lo();
    xfer(8'h11, 8, mi);
    xfer(8'h22, 8, mi);
    ss_hi();
    chk("ovr_rx", rx_data, 8'h11);
    chk("ovr_flag", rx_ovr, 1);
    chk("ovr_valid", rx_valid, 1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    chk("ovr_clr", rx_ovr, 0);
    ack();
    chk("ovr_ack", rx_valid, 0);

    // abort after 5 bits
    r0 = rises;
    ss_lo();
    xfer(8'hF0, 5, mi);
    ss_n = 1'b1;
    t = 0;
    while (tip && t < 10) begin
      cyc(1);
      t++;
    end
    chk("abort_tip", tip, 0);
    chk("abort_lat_ok", (t <= 3), 1);
    cyc(6);
    chk("abort_valid", rx_valid, 0);
    chk("abort_rises", rises - r0, 0);
    load(8'h5A);
    ss_lo();
    xfer(8'hE7, 8, mi);
    ss_hi();
    chk("post_abort_miso", mi, 8'h5A);
    chk("post_abort_rx", rx_data, 8'hE7);
    chk("post_abort_v", rx_valid, 1);
    ack();

    // reset mid-word
    load(8'hA5);
    ss_lo();
    xfer(8'h3C, 4, mi);
    preset_n = 1'b0;
    cyc(1);
    chk("mrst_miso", miso, 0);
    chk("mrst_oe", miso_oe, 0);
    chk("mrst_rx", rx_data, 0);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_ovr", rx_ovr, 0);
    chk("mrst_empty", tx_empty, 1);
    chk("mrst_tip", tip, 0);
    ss_n = 1'b1;
    sclk = cpol;
    mosi = 1'b0;
    cyc(2);
    preset_n = 1'b1;
    cyc(6);
    load(8'h3C);
    ss_lo();
    xfer(8'h81, 8, mi);
    ss_hi();
    chk("post_rst_miso", mi, 8'h3C);
    chk("post_rst_rx", rx_data, 8'h81);
    chk("post_rst_v", rx_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
